// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
//   Instruction fields and status (op, funct3, funct7_5, Zero, mem_ready) flow datapath -> controller.
//   Mux selects, enables, retire pulse, instret count and halted flag flow controller -> datapath.
//   master: controller side; slave: datapath side.
interface multicycle_controller_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7_5;
  logic                 Zero;
  logic                 mem_ready;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [2:0]           ALUControl;
  logic [1:0]           ImmSrc;
  logic                 RegWrite;
  logic                 retire;
  logic [CNT_WIDTH-1:0] instret;
  logic                 halted;

  modport master (
    input  op, funct3, funct7_5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
           RegWrite, retire, instret, halted
  );

  modport slave (
    output op, funct3, funct7_5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
           RegWrite, retire, instret, halted
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-memory multicycle RV32I datapath (one ALU, one memory).
// Each instruction takes 3-5 states; memory states wait on mem_ready. Unknown opcodes or
// unsupported funct3 values park the FSM in a sticky trap until reset.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : control bus (master side) -- instruction fields in, mux selects/enables out,
//          plus retire pulse, retired-instruction count (instret) and halted flag.
module multicycle_controller #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_controller_if.master  bus
);
  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBranch   = 4'd9;
  localparam logic [3:0] StJal      = 4'd10;
  localparam logic [3:0] StTrap     = 4'd11;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic [3:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 halted_q;

  logic       alu_ok;
  logic [2:0] alu_dec;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire;
  logic [1:0] result_src, src_a, src_b, imm_src;
  logic [2:0] alu_ctl;

  // ALU operation for EXECR/EXECI; alu_ok=0 flags an unsupported funct3.
  always_comb begin
    alu_ok  = 1'b1;
    alu_dec = 3'b000;
    case (bus.funct3)
      3'b000:  alu_dec = (state_q == StExecR && bus.funct7_5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_ok  = 1'b0;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OpStore:  imm_src = 2'b01;
      OpBranch: imm_src = 2'b10;
      OpJal:    imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = (bus.funct3[2:1] == 2'b00) ? StBranch : StTrap;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (bus.op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (bus.mem_ready) state_d = StFetch;
      StExecR,
      StExecI:    state_d = alu_ok ? StAluWb : StTrap;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJal:      state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_ctl    = 3'b000;
    case (state_q)
      StFetch: begin
        src_b      = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
      end
      StDecode: begin
        src_a = 2'b01;
        src_b = 2'b01;
      end
      StMemAdr: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      StMemRead:  adr_src = 1'b1;
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = bus.mem_ready;
      end
      StExecR: begin
        src_a   = 2'b10;
        alu_ctl = alu_dec;
      end
      StExecI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_ctl = alu_dec;
      end
      StAluWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      StBranch: begin
        src_a    = 2'b10;
        alu_ctl  = 3'b001;
        pc_write = (bus.funct3 == 3'b000) ? bus.Zero : ~bus.Zero;
        retire   = 1'b1;
      end
      StJal: begin
        src_a    = 2'b01;
        src_b    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are forced low during reset so an aborted instruction writes nothing.
  assign bus.PCWrite    = pc_write  & ~rst;
  assign bus.MemWrite   = mem_write & ~rst;
  assign bus.IRWrite    = ir_write  & ~rst;
  assign bus.RegWrite   = reg_write & ~rst;
  assign bus.retire     = retire    & ~rst;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = imm_src;
  assign bus.instret    = instret_q;
  assign bus.halted     = halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      instret_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.retire) instret_q <= instret_q + CNT_WIDTH'(1);
      if (state_q == StTrap) halted_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller. A per-instruction model derives the cycle length
// and the expected enable pattern of every cycle from the instruction class and the
// memory wait counts; instret is tracked with a narrow counter so wrap-around is exercised.
module tb_multicycle_controller;
  localparam int unsigned CW = 4;

  localparam int ClsR = 0, ClsI = 1, ClsLw = 2, ClsSw = 3, ClsBr = 4, ClsJal = 5;

  logic clk;
  logic rst;
  multicycle_controller_if #(.CNT_WIDTH(CW)) bus ();

  multicycle_controller #(.CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] model_instret;

  // {PCWrite, MemWrite, IRWrite, RegWrite, retire}
  logic [4:0] en;
  assign en = {bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.retire};

  logic [4:0] exp_en [64];
  logic       mr     [64];
  logic       zr     [64];

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (en !== 5'b0) begin
        n_errors++;
        $display("FAIL reset_enables: got %b want 00000", en);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model_instret = '0;
  endtask

  // Runs one instruction starting in FETCH; fw = fetch wait cycles, mw = data wait cycles.
  task automatic run_instr(input int cls, input int fw, input int mw);
    int len, ms, exec_idx;
    logic [2:0] f3, exp_alu;
    logic f7;
    logic [6:0] opc;
    logic [1:0] exp_imm;
    logic [2:0] alu_tab [4];
    logic [2:0] f3_tab [4];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b010; f3_tab[2] = 3'b110; f3_tab[3] = 3'b111;
    alu_tab[0] = 3'b000; alu_tab[1] = 3'b101; alu_tab[2] = 3'b011; alu_tab[3] = 3'b010;
    f7 = 1'($urandom);
    f3 = 3'($urandom);
    exp_alu = 3'b000;
    exp_imm = 2'b00;
    exec_idx = -1;
    ms = fw + 3;
    case (cls)
      ClsR, ClsI: begin
        int k = $urandom_range(0, 3);
        opc = (cls == ClsR) ? 7'b0110011 : 7'b0010011;
        f3 = f3_tab[k];
        exp_alu = alu_tab[k];
        if (k == 0 && cls == ClsR && f7) exp_alu = 3'b001;
        len = fw + 4;
        exec_idx = fw + 2;
      end
      ClsLw:  begin opc = 7'b0000011; f3 = 3'b010; len = fw + mw + 5; end
      ClsSw:  begin opc = 7'b0100011; f3 = 3'b010; len = fw + mw + 4; exp_imm = 2'b01; end
      ClsBr:  begin
        opc = 7'b1100011; f3 = {2'b00, 1'($urandom)}; len = fw + 3; exp_imm = 2'b10;
        exec_idx = fw + 2; exp_alu = 3'b001;
      end
      default: begin opc = 7'b1101111; len = fw + 4; exp_imm = 2'b11; end
    endcase
    for (int i = 0; i < len; i++) begin
      mr[i] = 1'($urandom);
      zr[i] = 1'($urandom);
      exp_en[i] = 5'b0;
    end
    for (int i = 0; i < fw; i++) mr[i] = 1'b0;
    mr[fw] = 1'b1;
    exp_en[fw] = 5'b10100;
    if (cls == ClsLw || cls == ClsSw) begin
      for (int i = ms; i < ms + mw; i++) mr[i] = 1'b0;
      mr[ms + mw] = 1'b1;
    end
    if (cls == ClsSw) for (int i = ms; i <= ms + mw; i++) exp_en[i] = 5'b01000;
    exp_en[len-1][0] = 1'b1;
    if (cls != ClsSw && cls != ClsBr) exp_en[len-1][1] = 1'b1;
    if (cls == ClsBr) exp_en[len-1][4] = (f3 == 3'b000) ? zr[len-1] : ~zr[len-1];
    if (cls == ClsJal) exp_en[fw+2][4] = 1'b1;

    bus.op = opc; bus.funct3 = f3; bus.funct7_5 = f7;
    for (int i = 0; i < len; i++) begin
      bus.mem_ready = mr[i];
      bus.Zero = zr[i];
      @(negedge clk);
      n_checks++;
      if (en !== exp_en[i]) begin
        n_errors++;
        $display("FAIL enables cls=%0d cyc=%0d: got %b want %b", cls, i, en, exp_en[i]);
      end
      if (i == exec_idx) begin
        n_checks++;
        if (bus.ALUControl !== exp_alu) begin
          n_errors++;
          $display("FAIL alucontrol cls=%0d f3=%b: got %b want %b", cls, f3, bus.ALUControl,
                   exp_alu);
        end
      end
      if (i == fw + 1) begin
        n_checks++;
        if (bus.ImmSrc !== exp_imm) begin
          n_errors++;
          $display("FAIL immsrc cls=%0d: got %b want %b", cls, bus.ImmSrc, exp_imm);
        end
      end
      if ((cls == ClsLw || cls == ClsSw) && i >= ms && i <= ms + mw) begin
        n_checks++;
        if (bus.AdrSrc !== 1'b1) begin
          n_errors++;
          $display("FAIL adrsrc cyc=%0d: got %b want 1", i, bus.AdrSrc);
        end
      end
      @(posedge clk); #1;
    end
    model_instret = model_instret + 1'b1;
    n_checks++;
    if (bus.instret !== model_instret) begin
      n_errors++;
      $display("FAIL instret cls=%0d: got %0d want %0d", cls, bus.instret, model_instret);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.instret !== '0 || bus.halted !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got instret=%0d halted=%b want 0 0", bus.instret, bus.halted);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (en !== 5'b10100) begin
      n_errors++;
      $display("FAIL first_fetch: got %b want 10100", en);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_alu();
    for (int n = 0; n < 8; n++) run_instr((n % 2 == 0) ? ClsR : ClsI, $urandom_range(0, 2), 0);
  endtask

  task automatic test_load_store();
    run_instr(ClsLw, 0, 3);
    run_instr(ClsSw, 0, 3);
    for (int n = 0; n < 4; n++) run_instr(ClsLw + (n % 2), $urandom_range(0, 2), $urandom_range(0, 4));
  endtask

  task automatic test_branch_jal();
    for (int n = 0; n < 6; n++) run_instr(ClsBr, $urandom_range(0, 1), 0);
    run_instr(ClsJal, 0, 0);
    run_instr(ClsJal, 2, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) run_instr($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  task automatic trap_case(input logic [6:0] opc, input logic [2:0] f3);
    logic [CW-1:0] frozen;
    do_reset();
    run_instr(ClsR, 0, 0);
    frozen = model_instret;
    bus.op = opc; bus.funct3 = f3; bus.funct7_5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = 1'b1;
      bus.Zero = 1'($urandom);
      @(negedge clk);
      if (i >= 3) begin
        n_checks++;
        if (en !== 5'b0) begin
          n_errors++;
          $display("FAIL trap_enables op=%b f3=%b cyc=%0d: got %b want 00000", opc, f3, i, en);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.halted !== 1'b1 || bus.instret !== frozen) begin
      n_errors++;
      $display("FAIL trap_state op=%b: got halted=%b instret=%0d want 1 %0d", opc, bus.halted,
               bus.instret, frozen);
    end
    do_reset();
    n_checks++;
    if (bus.halted !== 1'b0 || bus.instret !== '0) begin
      n_errors++;
      $display("FAIL trap_clear: got halted=%b instret=%0d want 0 0", bus.halted, bus.instret);
    end
  endtask

  task automatic test_trap();
    trap_case(7'h7F, 3'b000);
    trap_case(7'b0110011, 3'b001);
    trap_case(7'b1100011, 3'b100);
  endtask

  // Reset while MEMWRITE is stalled: write enable must drop on the reset cycle itself.
  task automatic test_reset_abort();
    do_reset();
    run_instr(ClsI, 0, 0);
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0; bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; bus.mem_ready = 1'b0; end
    @(negedge clk);
    n_checks++;
    if (bus.MemWrite !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_memwrite_pre: got %b want 1", bus.MemWrite);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (en !== 5'b0) begin
      n_errors++;
      $display("FAIL abort_reset_cycle: got %b want 00000", en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (en !== 5'b10100 || bus.instret !== '0) begin
      n_errors++;
      $display("FAIL abort_refetch: got en=%b instret=%0d want 10100 0", en, bus.instret);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus.op = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    model_instret = '0;
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jal();
    test_back_to_back();
    test_trap();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
